owl_dma_frame_sched: RTL and testbench
======================================

# owl_dma_frame_sched

Frame-buffer scheduler and sequencer for the `owl_dma_write` engine. It runs a ring of 3–4 DRAM frame buffers. For each frame it programs the engine's CPB registers (destination address, length, enable), waits for the engine's done interrupt, acknowledges and disables it, and hands the finished buffer to a downstream reader. The engine's CPB port is driven only by this block; the host CPU configures this block through its own register port.

## Interface

**Parameters**

- `APB_AW`, 5: address width of the host port and of the engine port.
- `NBUF`, 3: number of frame buffers. Legal values are 3 and 4.
- `LEN_RST`, 32'd1228800: reset value of the LEN register.

**Ports** (clock and reset first)

- `clk` in 1: single clock for the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_w` in 1: host register write strobe.
- `cfg_a` in `APB_AW`: host register address.
- `cfg_d` in 32: host write data.
- `cfg_q` out 32: host read data, combinational from `cfg_a`.
- `irq` out 1: frame-ready interrupt, level.
- `dma_cpb_w` out 1: write strobe to the engine.
- `dma_cpb_a` out `APB_AW`: engine register address.
- `dma_cpb_d` out 32: engine write data.
- `dma_irq` in 1: engine done interrupt, level.
- `rd_val` out 1: at least one READY buffer exists.
- `rd_adr` out 32: address of the oldest READY buffer.
- `rd_take` in 1: reader claims the `rd_adr` buffer.
- `rd_release` in 1: reader returns the buffer it holds.

## Operation

**Host registers**

- 0 CTRL, RW: bit0 `run`, bit1 `irq_en`. Reset 0.
- 1 BASE, RW: reset 0.
- 2 STRIDE, RW: reset 0.
- 3 LEN, RW: reset `LEN_RST`.
- 4 STAT:
  - Read fields: [15:0] frames completed, [23:16] frames dropped (both saturating), [24] `irq`, [26:25] writer buffer index, [27] busy (FSM not IDLE).
  - Write: bit0=1 clears `irq`; bit1=1 zeroes both counters.
- Any other address reads 0.

**Buffers**

- Address of buffer i is BASE + i*STRIDE, computed modulo 2^32.
- Each buffer is in one state: FREE, FILLING, READY or HELD. All buffers are FREE at reset.
- READY indices are kept in an age-ordered queue of depth `NBUF`.

**Buffer selection at frame start**

- Choose the lowest-index FREE buffer.
- If no buffer is FREE, take the oldest READY buffer off the queue and increment the drop counter.
- The reader holds at most one buffer, so with `NBUF` ≥ 3 a buffer is always available.

**FSM**

- IDLE: move to W_ADR when `run`=1. Buffer selection happens here; the chosen buffer becomes FILLING.
- W_ADR: write engine register 3 = buffer address.
- W_LEN: write engine register 4 = LEN.
- W_EN: write engine register 1 = 1.
- WAIT:
  - If `dma_irq`=1, go to W_ACK.
  - Else if `run`=0, abort: go to W_DIS and return the buffer to FREE, with no counter or irq update.
- W_ACK: write engine register 2 = 1.
- W_DIS: write engine register 1 = 0, then return to IDLE.
  - On the normal path the buffer becomes READY and is pushed on the queue.
  - Frames counter +1; `irq` is set if `irq_en`=1.
- States W_ADR, W_LEN, W_EN, W_ACK and W_DIS each last exactly one cycle and assert `dma_cpb_w` for that cycle only.

**Reader handshake**

- `rd_take` when `rd_val`=1 and nothing is held: pop the head of the queue; that buffer becomes HELD.
- `rd_take` when `rd_val`=0 or a buffer is already held: ignored.
- `rd_release` with a HELD buffer: that buffer becomes FREE. Otherwise ignored.

**Simultaneous events**

- In one cycle: `rd_take` pops first, then the writer's push is applied.
- A drop-steal in IDLE and `rd_take` in the same cycle: `rd_take` wins the head; the writer steals the next READY entry, or a FREE buffer if one remains.
- An `rd_release` is visible to IDLE selection in the following cycle.
- Host write of STAT bit0 in the same cycle as an irq set: set wins.

**Register writes during a frame**

- BASE, STRIDE and LEN writes while busy affect the next frame only. Address and length are sampled in IDLE.

## Timing

**Reset values**

- `irq`=0, `dma_cpb_w`=0, `dma_cpb_a`=0, `dma_cpb_d`=0.
- `rd_val`=0, `rd_adr`=BASE+0*STRIDE (0).
- All outputs are registered except `cfg_q`, `rd_val` and `rd_adr`, which decode combinationally from registered state.

**Latencies**

- `run` rising: `dma_cpb_w` first asserts 2 cycles later (1 cycle in IDLE, then W_ADR).
- Between frames: 5 write cycles plus IDLE, so the next W_ADR comes 2 cycles after W_DIS.
- `dma_irq` seen in WAIT: W_ACK next cycle; the buffer becomes READY and `rd_val` rises 2 cycles after that edge.

**Reset mid-operation**

- Everything returns to reset values. No engine writes are issued; the host re-initialises.

## Test plan

- **Single frame:** BASE=0x1000_0000, STRIDE=0x0012_C000, LEN=0x4B0, run=1. Expect writes (3,0x1000_0000), (4,0x4B0), (1,1) on consecutive cycles. Pulse `dma_irq` → writes (2,1), (1,0); `rd_adr`=0x1000_0000, `rd_val`=1, STAT[15:0]=1.
- **Rotation with reader:** 3 frames with the reader taking and releasing each promptly. Buffer addresses follow 0, 1, 0 (lowest-free rule); drops stay 0.
- **No reader, NBUF=3:** 5 frames. Buffers 0, 1, 2, then steal 0 and 1. Drops=2; the queue head becomes buffer 2.
- **Abort:** clear `run` in WAIT. Expect write (1,0), buffer FREE, frames=0, `irq`=0, FSM IDLE.
- **Irq handling:** `irq_en`=1, frame completes → `irq`=1 and STAT[24]=1. Host write STAT=1 → `irq`=0 next cycle. Write collides with a new set → `irq` stays 1.
- **Hold rule:** `rd_take` twice without `rd_release`. The second is ignored: the held buffer is unchanged and the queue is not popped.

Source files
------------

// File: rtl/owl_dma_frame_sched.sv
`default_nettype none
// ============================================================================
// owl_dma_frame_sched : frame-buffer ring scheduler driving the owl_dma_write
//                       CPB port, with host register block and reader handshake
// Revision 1.0
// ============================================================================
module owl_dma_frame_sched #(
  parameter int          APB_AW  = 5,
  parameter int          NBUF    = 3,
  parameter logic [31:0] LEN_RST = 32'd1228800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_w,
  input  logic [APB_AW-1:0] cfg_a,
  input  logic [31:0]       cfg_d,
  output logic [31:0]       cfg_q,
  output logic              irq,
  output logic              dma_cpb_w,
  output logic [APB_AW-1:0] dma_cpb_a,
  output logic [31:0]       dma_cpb_d,
  input  logic              dma_irq,
  output logic              rd_val,
  output logic [31:0]       rd_adr,
  input  logic              rd_take,
  input  logic              rd_release
);

  localparam int QW = 2 * NBUF;

  localparam logic [1:0] c_FREE  = 2'd0;
  localparam logic [1:0] c_FILL  = 2'd1;
  localparam logic [1:0] c_READY = 2'd2;
  localparam logic [1:0] c_HELD  = 2'd3;

  localparam logic [APB_AW-1:0] c_A_CTRL   = APB_AW'(0);
  localparam logic [APB_AW-1:0] c_A_BASE   = APB_AW'(1);
  localparam logic [APB_AW-1:0] c_A_STRIDE = APB_AW'(2);
  localparam logic [APB_AW-1:0] c_A_LEN    = APB_AW'(3);
  localparam logic [APB_AW-1:0] c_A_STAT   = APB_AW'(4);

  localparam logic [APB_AW-1:0] c_E_CTL = APB_AW'(1);
  localparam logic [APB_AW-1:0] c_E_ACK = APB_AW'(2);
  localparam logic [APB_AW-1:0] c_E_ADR = APB_AW'(3);
  localparam logic [APB_AW-1:0] c_E_LEN = APB_AW'(4);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_W_ADR = 3'd1,
    S_W_LEN = 3'd2,
    S_W_EN  = 3'd3,
    S_WAIT  = 3'd4,
    S_W_ACK = 3'd5,
    S_W_DIS = 3'd6
  } state_t;

  state_t              r_state;
  logic                r_run;
  logic                r_irq_en;
  logic [31:0]         r_base;
  logic [31:0]         r_stride;
  logic [31:0]         r_len;
  logic [31:0]         r_frame_len;
  logic [15:0]         r_frames;
  logic [7:0]          r_drops;
  logic                r_irq;
  logic [1:0]          r_wr_idx;
  logic                r_abort;
  logic                r_cpb_w;
  logic [APB_AW-1:0]   r_cpb_a;
  logic [31:0]         r_cpb_d;
  logic [1:0]          r_buf [NBUF];
  logic [QW-1:0]       r_q;       // READY indices, oldest in the low slot
  logic [2:0]          r_qcnt;
  logic                r_held;
  logic [1:0]          r_held_idx;

  logic                w_wr_ctrl;
  logic                w_wr_base;
  logic                w_wr_stride;
  logic                w_wr_len;
  logic                w_wr_stat;
  logic                w_free_any;
  logic [1:0]          w_free_idx;
  logic                w_take;
  logic                w_start;
  logic                w_steal;
  logic [1:0]          w_sel_idx;
  logic [31:0]         w_sel_adr;
  logic                w_done;
  logic                w_push;
  logic [1:0]          w_npop;
  logic [2:0]          w_cnt_after;
  logic [QW-1:0]       w_q_shift;
  logic [QW-1:0]       w_q_nx;
  logic [2:0]          w_qcnt_nx;

  assign w_wr_ctrl   = cfg_w && (cfg_a == c_A_CTRL);
  assign w_wr_base   = cfg_w && (cfg_a == c_A_BASE);
  assign w_wr_stride = cfg_w && (cfg_a == c_A_STRIDE);
  assign w_wr_len    = cfg_w && (cfg_a == c_A_LEN);
  assign w_wr_stat   = cfg_w && (cfg_a == c_A_STAT);

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = 2'd0;
    for (int i = NBUF - 1; i >= 0; i--) begin
      if (r_buf[i] == c_FREE) begin
        w_free_any = 1'b1;
        w_free_idx = 2'(i);
      end
    end
  end

  // The reader's pop is applied before the writer's steal, so a steal in the
  // same cycle as a take claims the second-oldest READY entry.
  assign w_take    = rd_take && (r_qcnt != 3'd0) && !r_held;
  assign w_start   = (r_state == S_IDLE) && r_run;
  assign w_steal   = w_start && !w_free_any;
  assign w_sel_idx = w_free_any ? w_free_idx : (w_take ? r_q[3:2] : r_q[1:0]);
  assign w_sel_adr = r_base + 32'(w_sel_idx) * r_stride;
  assign w_done    = (r_state == S_W_DIS);
  assign w_push    = w_done && !r_abort;
  assign w_npop    = {1'b0, w_take} + {1'b0, w_steal};

  always_comb begin
    w_q_shift   = r_q >> {w_npop, 1'b0};
    w_cnt_after = r_qcnt - {1'b0, w_npop};
    w_q_nx      = w_q_shift;
    w_qcnt_nx   = w_cnt_after;
    if (w_push) begin
      w_q_nx    = w_q_shift | (QW'(r_wr_idx) << {w_cnt_after, 1'b0});
      w_qcnt_nx = w_cnt_after + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_irq_en <= 1'b0;
      r_base   <= '0;
      r_stride <= '0;
      r_len    <= LEN_RST;
      r_frames <= '0;
      r_drops  <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl)   {r_irq_en, r_run} <= cfg_d[1:0];
      if (w_wr_base)   r_base   <= cfg_d;
      if (w_wr_stride) r_stride <= cfg_d;
      if (w_wr_len)    r_len    <= cfg_d;
      if (w_wr_stat && cfg_d[1]) begin
        r_frames <= '0;
        r_drops  <= '0;
      end else begin
        if (w_push && (r_frames != 16'hFFFF)) r_frames <= r_frames + 16'd1;
        if (w_steal && (r_drops != 8'hFF))    r_drops  <= r_drops + 8'd1;
      end
      if (w_push && r_irq_en)          r_irq <= 1'b1;
      else if (w_wr_stat && cfg_d[0])  r_irq <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= '0;
      r_qcnt     <= '0;
      r_held     <= 1'b0;
      r_held_idx <= '0;
      for (int i = 0; i < NBUF; i++) r_buf[i] <= c_FREE;
    end else begin
      r_q    <= w_q_nx;
      r_qcnt <= w_qcnt_nx;
      if (w_take) begin
        r_held     <= 1'b1;
        r_held_idx <= r_q[1:0];
      end else if (rd_release && r_held) begin
        r_held <= 1'b0;
      end
      for (int i = 0; i < NBUF; i++) begin
        if (w_take && (r_q[1:0] == 2'(i)))                r_buf[i] <= c_HELD;
        if (rd_release && r_held && (r_held_idx == 2'(i))) r_buf[i] <= c_FREE;
        if (w_start && (w_sel_idx == 2'(i)))              r_buf[i] <= c_FILL;
        if (w_done && (r_wr_idx == 2'(i)))                r_buf[i] <= r_abort ? c_FREE : c_READY;
      end
    end
  end

  // CPB outputs are registered on entry to each write state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cpb_w     <= 1'b0;
      r_cpb_a     <= '0;
      r_cpb_d     <= '0;
      r_wr_idx    <= '0;
      r_abort     <= 1'b0;
      r_frame_len <= '0;
    end else begin
      r_cpb_w <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_run) begin
            r_state     <= S_W_ADR;
            r_wr_idx    <= w_sel_idx;
            r_abort     <= 1'b0;
            r_frame_len <= r_len;
            r_cpb_w     <= 1'b1;
            r_cpb_a     <= c_E_ADR;
            r_cpb_d     <= w_sel_adr;
          end
        end
        S_W_ADR: begin
          r_state <= S_W_LEN;
          r_cpb_w <= 1'b1;
          r_cpb_a <= c_E_LEN;
          r_cpb_d <= r_frame_len;
        end
        S_W_LEN: begin
          r_state <= S_W_EN;
          r_cpb_w <= 1'b1;
          r_cpb_a <= c_E_CTL;
          r_cpb_d <= 32'd1;
        end
        S_W_EN: r_state <= S_WAIT;
        S_WAIT: begin
          if (dma_irq) begin
            r_state <= S_W_ACK;
            r_cpb_w <= 1'b1;
            r_cpb_a <= c_E_ACK;
            r_cpb_d <= 32'd1;
          end else if (!r_run) begin
            r_state <= S_W_DIS;
            r_abort <= 1'b1;
            r_cpb_w <= 1'b1;
            r_cpb_a <= c_E_CTL;
            r_cpb_d <= 32'd0;
          end
        end
        S_W_ACK: begin
          r_state <= S_W_DIS;
          r_cpb_w <= 1'b1;
          r_cpb_a <= c_E_CTL;
          r_cpb_d <= 32'd0;
        end
        S_W_DIS: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_q = '0;
    case (cfg_a)
      c_A_CTRL:   cfg_q = {30'd0, r_irq_en, r_run};
      c_A_BASE:   cfg_q = r_base;
      c_A_STRIDE: cfg_q = r_stride;
      c_A_LEN:    cfg_q = r_len;
      c_A_STAT:   cfg_q = {4'd0, (r_state != S_IDLE), r_wr_idx, r_irq, r_drops, r_frames};
      default:    cfg_q = '0;
    endcase
  end

  assign irq       = r_irq;
  assign dma_cpb_w = r_cpb_w;
  assign dma_cpb_a = r_cpb_a;
  assign dma_cpb_d = r_cpb_d;
  assign rd_val    = (r_qcnt != 3'd0);
  assign rd_adr    = r_base + 32'(r_q[1:0]) * r_stride;

endmodule
`default_nettype wire

// File: tb/tb_owl_dma_frame_sched.sv
`default_nettype none
// Randomised bench for owl_dma_frame_sched, checked against a queue-based buffer model.
module tb_owl_dma_frame_sched;

  localparam int          AW      = 5;
  localparam int          NB      = 3;
  localparam logic [31:0] LEN_RST = 32'd1228800;
  localparam int          M_FREE = 0, M_FILL = 1, M_READY = 2, M_HELD = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_w = 1'b0;
  logic [AW-1:0] cfg_a = '0;
  logic [31:0]   cfg_d = '0;
  logic [31:0]   cfg_q;
  logic          irq;
  logic          dma_cpb_w;
  logic [AW-1:0] dma_cpb_a;
  logic [31:0]   dma_cpb_d;
  logic          dma_irq = 1'b0;
  logic          rd_val;
  logic [31:0]   rd_adr;
  logic          rd_take = 1'b0;
  logic          rd_release = 1'b0;

  always #5 clk = ~clk;

  owl_dma_frame_sched #(.APB_AW(AW), .NBUF(NB), .LEN_RST(LEN_RST)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_w(cfg_w), .cfg_a(cfg_a), .cfg_d(cfg_d), .cfg_q(cfg_q),
    .irq(irq), .dma_cpb_w(dma_cpb_w), .dma_cpb_a(dma_cpb_a), .dma_cpb_d(dma_cpb_d),
    .dma_irq(dma_irq), .rd_val(rd_val), .rd_adr(rd_adr), .rd_take(rd_take),
    .rd_release(rd_release)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: per-buffer state, age-ordered READY list, held index.
  int          m_buf [NB];
  int          m_rq [$];
  int          m_held;
  logic [31:0] m_base, m_stride, m_len;
  bit          m_irq_en, m_irq;
  int          m_frames, m_drops;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input int a, input logic [31:0] d);
    cfg_w = 1'b1; cfg_a = AW'(a); cfg_d = d;
    tick();
    cfg_w = 1'b0;
  endtask

  function automatic logic [31:0] m_adr(input int i);
    return m_base + m_stride * 32'(i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_buf[i] = M_FREE;
    m_rq.delete();
    m_held = -1; m_base = '0; m_stride = '0; m_len = LEN_RST;
    m_irq_en = 1'b0; m_irq = 1'b0; m_frames = 0; m_drops = 0;
  endtask

  task automatic m_take();
    if (m_rq.size() > 0 && m_held < 0) begin
      m_held = m_rq.pop_front();
      m_buf[m_held] = M_HELD;
    end
  endtask

  task automatic m_select(output int idx);
    idx = -1;
    for (int i = NB - 1; i >= 0; i--) if (m_buf[i] == M_FREE) idx = i;
    if (idx < 0) begin
      idx = m_rq.pop_front();
      if (m_drops < 255) m_drops++;
    end
    m_buf[idx] = M_FILL;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; cfg_w = 1'b0; dma_irq = 1'b0; rd_take = 1'b0; rd_release = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic compare_model(input string tag, input bit exp_busy);
    logic [31:0] st;
    cfg_a = AW'(4); #1; st = cfg_q;
    checks++;
    if (rd_val !== (m_rq.size() > 0)) begin
      failures++; $display("FAIL %s rd_val: got %b expected %b", tag, rd_val, m_rq.size() > 0);
    end
    if (m_rq.size() > 0) begin
      checks++;
      if (rd_adr !== m_adr(m_rq[0])) begin
        failures++; $display("FAIL %s rd_adr: got %h expected %h", tag, rd_adr, m_adr(m_rq[0]));
      end
    end
    checks++;
    if ({st[27], st[24:0]} !== {exp_busy, m_irq, 8'(m_drops), 16'(m_frames)}) begin
      failures++;
      $display("FAIL %s stat: got %h expected busy=%b irq=%b drops=%0d frames=%0d",
               tag, st, exp_busy, m_irq, m_drops, m_frames);
    end
    checks++;
    if (irq !== m_irq) begin
      failures++; $display("FAIL %s irq: got %b expected %b", tag, irq, m_irq);
    end
  endtask

  // One complete frame: start from IDLE with run=0, end back in IDLE with run=0.
  task automatic run_frame(input bit take_at_start, input bit clr_at_done,
                           input int wait_cycles, output int idx);
    logic [31:0] ea;
    logic [31:0] st;
    host_wr(0, {30'd0, m_irq_en, 1'b1});
    if (take_at_start) rd_take = 1'b1;
    tick();
    rd_take = 1'b0;
    if (take_at_start) m_take();
    m_select(idx);
    ea = m_adr(idx);
    checks++;
    if ({dma_cpb_w, dma_cpb_a, dma_cpb_d} !== {1'b1, AW'(3), ea}) begin
      failures++; $display("FAIL frame_adr: got w=%b a=%0d d=%h expected a=3 d=%h", dma_cpb_w, dma_cpb_a, dma_cpb_d, ea);
    end
    tick();
    checks++;
    if ({dma_cpb_w, dma_cpb_a, dma_cpb_d} !== {1'b1, AW'(4), m_len}) begin
      failures++; $display("FAIL frame_len: got w=%b a=%0d d=%h expected a=4 d=%h", dma_cpb_w, dma_cpb_a, dma_cpb_d, m_len);
    end
    tick();
    checks++;
    if ({dma_cpb_w, dma_cpb_a, dma_cpb_d} !== {1'b1, AW'(1), 32'd1}) begin
      failures++; $display("FAIL frame_en: got w=%b a=%0d d=%h expected a=1 d=1", dma_cpb_w, dma_cpb_a, dma_cpb_d);
    end
    tick();
    cfg_a = AW'(4); #1; st = cfg_q;
    checks++;
    if ({dma_cpb_w, st[27:25]} !== {1'b0, 1'b1, 2'(idx)}) begin
      failures++; $display("FAIL frame_wait: got w=%b busy/idx=%b expected w=0 busy=1 idx=%0d", dma_cpb_w, st[27:25], idx);
    end
    for (int i = 0; i < wait_cycles; i++) begin
      tick();
      checks++;
      if (dma_cpb_w !== 1'b0) begin
        failures++; $display("FAIL frame_idle_write: got w=%b expected 0", dma_cpb_w);
      end
    end
    dma_irq = 1'b1;
    tick();
    dma_irq = 1'b0;
    checks++;
    if ({dma_cpb_w, dma_cpb_a, dma_cpb_d} !== {1'b1, AW'(2), 32'd1}) begin
      failures++; $display("FAIL frame_ack: got w=%b a=%0d d=%h expected a=2 d=1", dma_cpb_w, dma_cpb_a, dma_cpb_d);
    end
    host_wr(0, {30'd0, m_irq_en, 1'b0});
    checks++;
    if ({dma_cpb_w, dma_cpb_a, dma_cpb_d} !== {1'b1, AW'(1), 32'd0}) begin
      failures++; $display("FAIL frame_dis: got w=%b a=%0d d=%h expected a=1 d=0", dma_cpb_w, dma_cpb_a, dma_cpb_d);
    end
    if (clr_at_done) host_wr(4, 32'd1);
    else tick();
    m_buf[idx] = M_READY;
    m_rq.push_back(idx);
    if (m_frames < 65535) m_frames++;
    if (m_irq_en) m_irq = 1'b1;
    else if (clr_at_done) m_irq = 1'b0;
    checks++;
    if (dma_cpb_w !== 1'b0) begin
      failures++; $display("FAIL frame_end_write: got w=%b expected 0", dma_cpb_w);
    end
    compare_model("frame_end", 1'b0);
  endtask

  task automatic run_abort(output int idx);
    host_wr(0, {30'd0, m_irq_en, 1'b1});
    tick();
    m_select(idx);
    checks++;
    if ({dma_cpb_w, dma_cpb_a, dma_cpb_d} !== {1'b1, AW'(3), m_adr(idx)}) begin
      failures++; $display("FAIL abort_adr: got a=%0d d=%h expected a=3 d=%h", dma_cpb_a, dma_cpb_d, m_adr(idx));
    end
    tick(); tick(); tick();
    host_wr(0, {30'd0, m_irq_en, 1'b0});
    checks++;
    if (dma_cpb_w !== 1'b0) begin
      failures++; $display("FAIL abort_wait: got w=%b expected 0", dma_cpb_w);
    end
    tick();
    checks++;
    if ({dma_cpb_w, dma_cpb_a, dma_cpb_d} !== {1'b1, AW'(1), 32'd0}) begin
      failures++; $display("FAIL abort_dis: got w=%b a=%0d d=%h expected a=1 d=0", dma_cpb_w, dma_cpb_a, dma_cpb_d);
    end
    tick();
    m_buf[idx] = M_FREE;
    compare_model("abort_end", 1'b0);
  endtask

  task automatic reader_take();
    rd_take = 1'b1; tick(); rd_take = 1'b0;
    m_take();
    compare_model("take", 1'b0);
  endtask

  task automatic reader_release();
    rd_release = 1'b1; tick(); rd_release = 1'b0;
    if (m_held >= 0) begin
      m_buf[m_held] = M_FREE;
      m_held = -1;
    end
    compare_model("release", 1'b0);
  endtask

  task automatic set_geom(input logic [31:0] b, input logic [31:0] s, input logic [31:0] l);
    host_wr(1, b); host_wr(2, s); host_wr(3, l);
    m_base = b; m_stride = s; m_len = l;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    apply_reset();
    checks++;
    if ({irq, dma_cpb_w, rd_val, dma_cpb_a, dma_cpb_d, rd_adr} !== '0) begin
      failures++; $display("FAIL reset_outputs: got irq=%b w=%b val=%b a=%0d d=%h adr=%h expected all 0",
                           irq, dma_cpb_w, rd_val, dma_cpb_a, dma_cpb_d, rd_adr);
    end
    for (int a = 0; a < 8; a++) begin
      cfg_a = AW'(a); #1;
      exp = (a == 3) ? LEN_RST : 32'd0;
      checks++;
      if (cfg_q !== exp) begin
        failures++; $display("FAIL reset_reg%0d: got %h expected %h", a, cfg_q, exp);
      end
    end
  endtask

  task automatic test_single_frame();
    int idx;
    set_geom(32'h1000_0000, 32'h0012_C000, 32'h4B0);
    run_frame(1'b0, 1'b0, 2, idx);
    cfg_a = AW'(4); #1;
    checks++;
    if ({rd_val, rd_adr, cfg_q[15:0]} !== {1'b1, 32'h1000_0000, 16'd1}) begin
      failures++; $display("FAIL single_frame: got val=%b adr=%h frames=%0d expected 1 10000000 1", rd_val, rd_adr, cfg_q[15:0]);
    end
  endtask

  task automatic test_rotation();
    int idx;
    int exp_seq [3] = '{0, 1, 0};
    apply_reset();
    set_geom($urandom, $urandom, $urandom);
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0, 1'b0, $urandom_range(0, 3), idx);
      checks++;
      if (idx !== exp_seq[f]) begin
        failures++; $display("FAIL rotation_idx%0d: got %0d expected %0d", f, idx, exp_seq[f]);
      end
      reader_release();
      reader_take();
    end
  endtask

  task automatic test_no_reader();
    int idx;
    int exp_seq [5] = '{0, 1, 2, 0, 1};
    apply_reset();
    set_geom($urandom, $urandom | 32'h10, $urandom);
    for (int f = 0; f < 5; f++) begin
      run_frame(1'b0, 1'b0, $urandom_range(0, 2), idx);
      checks++;
      if (idx !== exp_seq[f]) begin
        failures++; $display("FAIL noreader_idx%0d: got %0d expected %0d", f, idx, exp_seq[f]);
      end
    end
    cfg_a = AW'(4); #1;
    checks++;
    if ({cfg_q[23:16], rd_adr} !== {8'd2, m_base + 32'd2 * m_stride}) begin
      failures++; $display("FAIL noreader_drops: got drops=%0d adr=%h expected 2 %h", cfg_q[23:16], rd_adr, m_base + 32'd2 * m_stride);
    end
  endtask

  task automatic test_back_to_back_take_steal();
    int idx;
    // Queue is 2,0,1 with nothing free: take gets 2, writer steals 0.
    run_frame(1'b1, 1'b0, 1, idx);
    checks++;
    if (idx !== 0) begin
      failures++; $display("FAIL collide_idx: got %0d expected 0", idx);
    end
  endtask

  task automatic test_hold();
    int idx;
    apply_reset();
    set_geom($urandom, $urandom, $urandom);
    run_frame(1'b0, 1'b0, 0, idx);
    run_frame(1'b0, 1'b0, 0, idx);
    reader_take();
    reader_take();
    checks++;
    if ({rd_val, rd_adr} !== {1'b1, m_stride + m_base}) begin
      failures++; $display("FAIL hold_second_take: got val=%b adr=%h expected 1 %h", rd_val, rd_adr, m_base + m_stride);
    end
    reader_release();
    run_frame(1'b0, 1'b0, 0, idx);
    checks++;
    if (idx !== 0) begin
      failures++; $display("FAIL hold_release_idx: got %0d expected 0", idx);
    end
  endtask

  task automatic test_abort();
    int idx, idx2;
    run_abort(idx);
    checks++;
    if (idx !== 2) begin
      failures++; $display("FAIL abort_idx: got %0d expected 2", idx);
    end
    run_frame(1'b0, 1'b0, 0, idx2);
    checks++;
    if (idx2 !== 2) begin
      failures++; $display("FAIL abort_reuse: got %0d expected 2", idx2);
    end
  endtask

  task automatic test_irq();
    int idx;
    apply_reset();
    m_irq_en = 1'b1;
    run_frame(1'b0, 1'b0, 1, idx);
    host_wr(4, 32'd1);
    m_irq = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_clear: got %b expected 0", irq);
    end
    run_frame(1'b0, 1'b1, 1, idx);
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL irq_set_wins: got %b expected 1", irq);
    end
    host_wr(4, 32'd2);
    m_frames = 0; m_drops = 0;
    compare_model("counter_clear", 1'b0);
  endtask

  task automatic test_random();
    int idx;
    apply_reset();
    set_geom($urandom, $urandom, $urandom);
    m_irq_en = 1'($urandom_range(0, 1));
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), idx);
        4: run_abort(idx);
        5, 6: reader_take();
        7: reader_release();
        8: begin host_wr(1, it * 32'h0101_0000); m_base = it * 32'h0101_0000; end
        default: begin host_wr(4, 32'd1); m_irq = 1'b0; end
      endcase
    end
  endtask

  task automatic test_reset_mid();
    int idx;
    apply_reset();
    set_geom($urandom, $urandom, $urandom);
    m_irq_en = 1'b1;
    run_frame(1'b0, 1'b0, 0, idx);
    host_wr(0, 32'h3);
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({irq, dma_cpb_w, rd_val, dma_cpb_a, dma_cpb_d, rd_adr} !== '0) begin
      failures++; $display("FAIL midreset_outputs: got irq=%b w=%b val=%b a=%0d d=%h adr=%h expected all 0",
                           irq, dma_cpb_w, rd_val, dma_cpb_a, dma_cpb_d, rd_adr);
    end
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dma_cpb_w !== 1'b0) begin
        failures++; $display("FAIL midreset_write: got w=%b expected 0", dma_cpb_w);
      end
    end
    compare_model("midreset", 1'b0);
    run_frame(1'b0, 1'b0, 0, idx);
    checks++;
    if (idx !== 0) begin
      failures++; $display("FAIL midreset_idx: got %0d expected 0", idx);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_rotation();
    test_no_reader();
    test_back_to_back_take_steal();
    test_hold();
    test_abort();
    test_irq();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
